// File: rtl/reset_request_sequencer.sv
// Counted active-low reset generator with propagation acknowledge via a synchronized return path.
// Optional ack-wait timeout is built when RSTSEQ_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | OUT_RST_N released, ready to accept a request
// ST_ASSERT  | OUT_RST_N held low, counting hold cycles and watching for ack low
// ST_RELEASE | OUT_RST_N released, waiting for the synchronized reset to rise
module reset_request_sequencer #(
    parameter int CW             = 8,
    parameter int DEFAULT_HOLD   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [CW-1:0] REQ_CYCLES,
    output logic          OUT_RST_N,
    input  logic          SYNC_RST_N,
    output logic          BUSY,
    output logic          DONE,
    output logic          TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_low_q, seen_low_d;
    logic [1:0]    sync_ff;
    logic          s_sync;
    logic          tmo_hit;

    assign s_sync = sync_ff[1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], SYNC_RST_N};
        end
    end

`ifdef RSTSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmr_q;
    logic          waiting;

    // Down-counter reloads on any state change or while not waiting on the ack.
    assign waiting = ((state_q == ST_ASSERT) && (cnt_q == CW'(1))) || (state_q == ST_RELEASE);
    assign tmo_hit = waiting && (tmr_q == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmr_q <= TW'(TIMEOUT_CYCLES);
        end else if ((state_d != state_q) || !waiting) begin
            tmr_q <= TW'(TIMEOUT_CYCLES);
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_low_d = seen_low_q;
        DONE       = 1'b0;
        TIMEOUT    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    state_d    = ST_ASSERT;
                    cnt_d      = (REQ_CYCLES == '0) ? CW'(1) : REQ_CYCLES;
                    seen_low_d = 1'b0;
                end
            end
            ST_ASSERT: begin
                if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (!s_sync) begin
                    seen_low_d = 1'b1;
                end
                if ((cnt_q == CW'(1)) && (seen_low_q || !s_sync)) begin
                    state_d = ST_RELEASE;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    DONE    = 1'b1;
                    TIMEOUT = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (s_sync) begin
                    state_d = ST_IDLE;
                    DONE    = 1'b1;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    DONE    = 1'b1;
                    TIMEOUT = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Power-on lands in ST_ASSERT so a full default-length sequence always runs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= CW'(DEFAULT_HOLD);
            seen_low_q <= 1'b0;
            OUT_RST_N  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_low_q <= seen_low_d;
            OUT_RST_N  <= (state_d != ST_ASSERT);
        end
    end

    assign BUSY      = (state_q != ST_IDLE);
    assign REQ_READY = (state_q == ST_IDLE);

endmodule

// File: tb/tb_reset_request_sequencer.sv
// Directed bench for reset_request_sequencer; SYNC_RST_N modelled as OUT_RST_N delayed two cycles.
module tb_reset_request_sequencer;

    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic [CW-1:0] REQ_CYCLES = '0;
    logic          OUT_RST_N;
    logic          SYNC_RST_N;
    logic          BUSY;
    logic          DONE;
    logic          TIMEOUT;

    logic d1 = 1'b0;
    logic d2 = 1'b0;
    logic stuck = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    int m_low, m_done, m_tmo, m_rise, m_done_idx, m_tmo_idx, m_rdy_busy;
    logic m_fin;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        d1 <= OUT_RST_N;
        d2 <= d1;
    end

    assign SYNC_RST_N = stuck ? 1'b1 : d2;

    reset_request_sequencer #(
        .CW(CW),
        .DEFAULT_HOLD(16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_CYCLES(REQ_CYCLES),
        .OUT_RST_N(OUT_RST_N),
        .SYNC_RST_N(SYNC_RST_N),
        .BUSY(BUSY),
        .DONE(DONE),
        .TIMEOUT(TIMEOUT)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Samples at the current negedge (index 0) and each following negedge until BUSY drops.
    task automatic measure(input int max_cycles);
        m_low = 0; m_done = 0; m_tmo = 0; m_rise = -1;
        m_done_idx = -1; m_tmo_idx = -1; m_rdy_busy = 0; m_fin = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!BUSY) begin
                m_fin = 1'b1;
                break;
            end
            if (!OUT_RST_N) m_low++;
            if (OUT_RST_N && (m_rise < 0)) m_rise = i;
            if (DONE) begin
                m_done++;
                m_done_idx = i;
            end
            if (TIMEOUT) begin
                m_tmo++;
                m_tmo_idx = i;
            end
            if (REQ_READY) m_rdy_busy++;
            @(negedge CLK);
        end
    endtask

    task automatic request(input logic [CW-1:0] n);
        REQ_VALID  = 1'b1;
        REQ_CYCLES = n;
        @(negedge CLK);
        REQ_VALID  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (3) @(negedge CLK);
        check1("rst_out", OUT_RST_N, 1'b0);
        check1("rst_busy", BUSY, 1'b1);
        check1("rst_ready", REQ_READY, 1'b0);
        check1("rst_done", DONE, 1'b0);
        check1("rst_timeout", TIMEOUT, 1'b0);
        RST_N = 1'b1;
        measure(100);
        check1("por_fin", m_fin, 1'b1);
        checkn("por_low", m_low, 16);
        checkn("por_rise", m_rise, 16);
        checkn("por_done_cnt", m_done, 1);
        checkn("por_done_idx", m_done_idx, 20);
        checkn("por_tmo", m_tmo, 0);
        check1("por_idle_ready", REQ_READY, 1'b1);
        check1("por_idle_out", OUT_RST_N, 1'b1);

        // Request of 5 cycles
        request(8'd5);
        measure(100);
        check1("r5_fin", m_fin, 1'b1);
        checkn("r5_low", m_low, 5);
        checkn("r5_rise", m_rise, 5);
        checkn("r5_done_cnt", m_done, 1);
        checkn("r5_done_idx", m_done_idx, 9);
        checkn("r5_ready_busy", m_rdy_busy, 0);

        // Zero treated as one; ack latency stretches the low time
        request(8'd0);
        measure(100);
        checkn("r0_low", m_low, 5);
        checkn("r0_done_cnt", m_done, 1);
        checkn("r0_done_idx", m_done_idx, 9);

        // Maximum hold
        request(8'd255);
        measure(400);
        check1("r255_fin", m_fin, 1'b1);
        checkn("r255_low", m_low, 255);
        checkn("r255_done_idx", m_done_idx, 259);

        // Ack never arrives
        stuck = 1'b1;
        request(8'd3);
`ifdef RSTSEQ_TIMEOUT_EN
        measure(200);
        check1("tmo_fin", m_fin, 1'b1);
        checkn("tmo_low", m_low, 67);
        checkn("tmo_done_cnt", m_done, 1);
        checkn("tmo_done_idx", m_done_idx, 66);
        checkn("tmo_tmo_idx", m_tmo_idx, 66);
        check1("tmo_out_after", OUT_RST_N, 1'b1);
        stuck = 1'b0;
`else
        measure(200);
        check1("stuck_fin", m_fin, 1'b0);
        checkn("stuck_low", m_low, 200);
        checkn("stuck_done_cnt", m_done, 0);
        check1("stuck_busy", BUSY, 1'b1);
        stuck = 1'b0;
        measure(50);
        checkn("unstuck_low", m_low, 3);
        checkn("unstuck_done_idx", m_done_idx, 7);
        checkn("unstuck_tmo", m_tmo, 0);
`endif

        // Reset during RELEASE
        request(8'd5);
        repeat (6) @(negedge CLK);
        check1("abort_pre_out", OUT_RST_N, 1'b1);
        check1("abort_pre_busy", BUSY, 1'b1);
        RST_N = 1'b0;
        #1;
        check1("abort_async_out", OUT_RST_N, 1'b0);
        check1("abort_done", DONE, 1'b0);
        check1("abort_ready", REQ_READY, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        measure(100);
        checkn("abort_low", m_low, 16);
        checkn("abort_done_cnt", m_done, 1);
        checkn("abort_done_idx", m_done_idx, 20);

        // Request held across a sequence
        REQ_VALID  = 1'b1;
        REQ_CYCLES = 8'd5;
        @(negedge CLK);
        REQ_CYCLES = 8'd8;
        measure(100);
        checkn("held1_low", m_low, 5);
        checkn("held1_done_cnt", m_done, 1);
        checkn("held1_ready_busy", m_rdy_busy, 0);
        check1("held1_ready_idle", REQ_READY, 1'b1);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        measure(100);
        checkn("held2_low", m_low, 8);
        checkn("held2_done_cnt", m_done, 1);
        checkn("held2_done_idx", m_done_idx, 12);
        measure(10);
        check1("held_no_third", m_fin, 1'b1);
        repeat (10) @(negedge CLK);
        check1("held_idle_busy", BUSY, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
